pc_unit: RTL and testbench

//  Program-counter generation stage, directly upstream of instruction fetch. Holds the architectural PC
//  and drives it as the fetch address every cycle. Selects next PC from +4, branch, JALR or trap vector.

---
 rtl/pc_unit_if.sv | 49 ++++
 rtl/pc_unit.sv | 143 ++++++++++++++
 tb/tb_pc_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Bundle of pc_unit control inputs and status outputs.
// Trace signals exist only when PC_TRACE_EN is defined.
interface pc_unit_if #(
    parameter int unsigned TRACE_DEPTH = 8
);
    localparam int unsigned IdxW = $clog2(TRACE_DEPTH);

    logic        stall;
    logic        halt_req;
    logic        resume;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        jalr_valid;
    logic [63:0] jalr_target;
    logic        trap_req;
    logic [63:0] trap_vector;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        misaligned;
    logic [63:0] bad_addr;
    logic        halted;
    logic        faulted;
    logic [63:0] retire_count;
`ifdef PC_TRACE_EN
    logic [IdxW-1:0] trace_idx;
    logic [63:0]     trace_pc;
    logic [IdxW:0]   trace_count;
`endif

    modport master (
        output stall, halt_req, resume, branch_taken, branch_target,
        output jalr_valid, jalr_target, trap_req, trap_vector,
        input  pc, pc_plus4, misaligned, bad_addr, halted, faulted, retire_count
`ifdef PC_TRACE_EN
        , output trace_idx
        , input  trace_pc, trace_count
`endif
    );

    modport slave (
        input  stall, halt_req, resume, branch_taken, branch_target,
        input  jalr_valid, jalr_target, trap_req, trap_vector,
        output pc, pc_plus4, misaligned, bad_addr, halted, faulted, retire_count
`ifdef PC_TRACE_EN
        , input  trace_idx
        , output trace_pc, trace_count
`endif
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: registered next-PC select, halt/fault tracking, retire counter.
// Optional redirect trace ring buffer enabled by defining PC_TRACE_EN.
module pc_unit #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int unsigned TRACE_DEPTH  = 8
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);
    typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] bad_addr_q, bad_addr_d;
    logic [63:0] retire_q, retire_d;
    logic        misaligned_q, misaligned_d;
    logic        redirect_ok;
    logic [63:0] pc_plus4;
    logic [63:0] jalr_tgt;

    assign pc_plus4 = pc_q + 64'd4;
    assign jalr_tgt = bus.jalr_target & ~64'd1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        bad_addr_d   = bad_addr_q;
        retire_d     = retire_q;
        misaligned_d = 1'b0;
        redirect_ok  = 1'b0;
        if (bus.trap_req) begin
            pc_d        = bus.trap_vector;
            state_d     = StRun;
            redirect_ok = 1'b1;
            if (state_q == StRun) retire_d = retire_q + 64'd1;
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.halt_req) begin
                        state_d = StHalted;
                    end else if (bus.stall) begin
                        state_d = StRun;
                    end else if (bus.jalr_valid) begin
                        // bit0 is already cleared, so only bit1 can make the target misaligned
                        if (jalr_tgt[1]) begin
                            misaligned_d = 1'b1;
                            bad_addr_d   = jalr_tgt;
                            state_d      = StFault;
                        end else begin
                            pc_d        = jalr_tgt;
                            retire_d    = retire_q + 64'd1;
                            redirect_ok = 1'b1;
                        end
                    end else if (bus.branch_taken) begin
                        if (bus.branch_target[1:0] != 2'b00) begin
                            misaligned_d = 1'b1;
                            bad_addr_d   = bus.branch_target;
                            state_d      = StFault;
                        end else begin
                            pc_d        = bus.branch_target;
                            retire_d    = retire_q + 64'd1;
                            redirect_ok = 1'b1;
                        end
                    end else begin
                        pc_d     = pc_plus4;
                        retire_d = retire_q + 64'd1;
                    end
                end
                StHalted: begin
                    if (bus.resume && !bus.halt_req) state_d = StRun;
                end
                default: state_d = StFault;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= RESET_VECTOR;
            bad_addr_q   <= 64'd0;
            retire_q     <= 64'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            bad_addr_q   <= bad_addr_d;
            retire_q     <= retire_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.misaligned   = misaligned_q;
    assign bus.bad_addr     = bad_addr_q;
    assign bus.halted       = (state_q == StHalted);
    assign bus.faulted      = (state_q == StFault);
    assign bus.retire_count = retire_q;

`ifdef PC_TRACE_EN
    localparam int unsigned    IdxW     = $clog2(TRACE_DEPTH);
    localparam logic [IdxW:0]  MaxCount = (IdxW + 1)'(TRACE_DEPTH);

    logic [63:0]     trace_buf_q [TRACE_DEPTH];
    logic [IdxW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr;
    logic [IdxW:0]   trace_count_q, trace_count_d;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        trace_count_d = trace_count_q;
        if (redirect_ok) begin
            wr_ptr_d = wr_ptr_q + IdxW'(1);
            if (trace_count_q != MaxCount) trace_count_d = trace_count_q + (IdxW + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            trace_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            trace_count_q <= trace_count_d;
        end
    end

    // Contents need no reset; trace_count masks stale entries.
    always_ff @(posedge clk) begin
        if (redirect_ok && !reset) trace_buf_q[wr_ptr_q] <= pc_q;
    end

    assign rd_ptr          = wr_ptr_q - IdxW'(1) - bus.trace_idx;
    assign bus.trace_count = trace_count_q;
    assign bus.trace_pc    = ({1'b0, bus.trace_idx} < trace_count_q) ? trace_buf_q[rd_ptr] : 64'd0;
`else
    logic        unused_redirect;
    logic [31:0] unused_trace_depth;
    assign unused_redirect    = redirect_ok;
    assign unused_trace_depth = TRACE_DEPTH;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, corner sequences, random vs. model.
module tb_pc_unit;
    localparam logic [63:0] RV = 64'h1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.TRACE_DEPTH(8)) bus ();

    pc_unit #(.RESET_VECTOR(RV), .TRACE_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall, halt, resume, br;
        logic [63:0] brt;
        logic        jv;
        logic [63:0] jt;
        logic        trap;
        logic [63:0] tv;
        logic [63:0] e_pc, e_cnt;
        logic        e_mis, e_halt, e_flt;
        logic [63:0] e_bad;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: mode 0=run 1=halted 2=fault.
    logic [63:0] m_pc, m_cnt, m_bad;
    logic        m_mis;
    int          m_mode;
    logic [63:0] m_tq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, h, r, b, input logic [63:0] bt, input logic j,
                       input logic [63:0] jt, input logic t, input logic [63:0] tv,
                       input logic [63:0] epc, ecnt, input logic emis, ehalt, eflt,
                       input logic [63:0] ebad);
        vec_t v;
        v = '{s, h, r, b, bt, j, jt, t, tv, epc, ecnt, emis, ehalt, eflt, ebad};
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.stall         = v.stall;
        bus.halt_req      = v.halt;
        bus.resume        = v.resume;
        bus.branch_taken  = v.br;
        bus.branch_target = v.brt;
        bus.jalr_valid    = v.jv;
        bus.jalr_target   = v.jt;
        bus.trap_req      = v.trap;
        bus.trap_vector   = v.tv;
    endtask

    task automatic idle();
        vec_t v;
        v = '{0, 0, 0, 0, 64'd0, 0, 64'd0, 0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 64'd0};
        drive(v);
    endtask

    task automatic model_reset();
        m_pc = RV; m_cnt = 0; m_bad = 0; m_mis = 0; m_mode = 0;
        m_tq.delete();
    endtask

    task automatic model_step();
        logic [63:0] t;
        logic [63:0] old;
        bit          acc;
        old = m_pc;
        acc = 0;
        m_mis = 0;
        if (bus.trap_req) begin
            if (m_mode == 0) m_cnt++;
            m_pc = bus.trap_vector; m_mode = 0; acc = 1;
        end else if (m_mode == 1) begin
            if (bus.resume && !bus.halt_req) m_mode = 0;
        end else if (m_mode == 0 && bus.halt_req) begin
            m_mode = 1;
        end else if (m_mode == 0 && !bus.stall) begin
            if (bus.jalr_valid)        t = bus.jalr_target & ~64'd1;
            else if (bus.branch_taken) t = bus.branch_target;
            else                       t = m_pc + 64'd4;
            if (t % 4 != 0) begin
                m_mis = 1; m_bad = t; m_mode = 2;
            end else begin
                m_pc = t; m_cnt++;
                acc = bus.jalr_valid || bus.branch_taken;
            end
        end
        if (acc) begin
            m_tq.push_front(old);
            if (m_tq.size() > 8) void'(m_tq.pop_back());
        end
    endtask

    function automatic logic [63:0] rnd_addr(input bit allow_mis);
        logic [63:0] a;
        a = {$urandom(), $urandom()} & ~64'd3;
        if (allow_mis && $urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        logic [63:0] p[10];
        idle();
`ifdef PC_TRACE_EN
        bus.trace_idx = '0;
`endif
        // Reset state
        #12;
        chk("rst pc", bus.pc, RV);
        chk("rst cnt", bus.retire_count, 64'd0);
        chk("rst halted", bus.halted, 0);
        chk("rst faulted", bus.faulted, 0);
        chk("rst mis", bus.misaligned, 0);
        chk("rst bad", bus.bad_addr, 64'd0);
        chk("rst plus4", bus.pc_plus4, RV + 64'd4);
        @(negedge clk) reset = 1'b0;

        //  s  h  r  b  brt                     j  jt        t  tv        pc                      cnt  mis hlt flt bad
        add(0, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h1004,               1,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h1008,               2,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h100C,               3,  0, 0, 0, 0);
        add(1, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h100C,               3,  0, 0, 0, 0);
        add(0, 0, 0, 1, 64'h2000,               1, 64'h3001, 0, 0,        64'h3000,               4,  0, 0, 0, 0);
        add(0, 0, 0, 1, 64'h2002,               0, 0,        0, 0,        64'h3000,               4,  1, 0, 1, 64'h2002);
        add(0, 1, 0, 1, 64'h4000,               0, 0,        0, 0,        64'h3000,               4,  0, 0, 1, 64'h2002);
        add(0, 0, 0, 0, 0,                      0, 0,        1, 64'h8000, 64'h8000,               4,  0, 0, 0, 64'h2002);
        add(0, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h8004,               5,  0, 0, 0, 64'h2002);
        add(0, 1, 0, 0, 0,                      0, 0,        0, 0,        64'h8004,               5,  0, 1, 0, 64'h2002);
        add(0, 0, 0, 1, 64'h9000,               0, 0,        0, 0,        64'h8004,               5,  0, 1, 0, 64'h2002);
        add(1, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h8004,               5,  0, 1, 0, 64'h2002);
        add(0, 0, 0, 0, 0,                      1, 64'h9000, 0, 0,        64'h8004,               5,  0, 1, 0, 64'h2002);
        add(0, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h8004,               5,  0, 1, 0, 64'h2002);
        add(0, 1, 1, 0, 0,                      0, 0,        0, 0,        64'h8004,               5,  0, 1, 0, 64'h2002);
        add(0, 0, 1, 0, 0,                      0, 0,        0, 0,        64'h8004,               5,  0, 0, 0, 64'h2002);
        add(0, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h8008,               6,  0, 0, 0, 64'h2002);
        add(0, 0, 0, 0, 0,                      1, 64'h5003, 0, 0,        64'h8008,               6,  1, 0, 1, 64'h5002);
        add(0, 0, 0, 0, 0,                      0, 0,        1, 64'h100,  64'h100,                6,  0, 0, 0, 64'h5002);
        add(0, 0, 0, 0, 0,                      0, 0,        1, 64'h200,  64'h200,                7,  0, 0, 0, 64'h5002);
        add(0, 1, 0, 0, 0,                      0, 0,        1, 64'h300,  64'h300,                8,  0, 0, 0, 64'h5002);
        add(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0,       0, 0,        64'hFFFF_FFFF_FFFF_FFFC, 9,  0, 0, 0, 64'h5002);
        add(0, 0, 0, 0, 0,                      0, 0,        0, 0,        64'h0,                  10, 0, 0, 0, 64'h5002);
        add(0, 0, 0, 0, 0,                      1, 64'h7001, 0, 0,        64'h7000,               11, 0, 0, 0, 64'h5002);
        add(1, 0, 0, 0, 0,                      1, 64'h9000, 0, 0,        64'h7000,               11, 0, 0, 0, 64'h5002);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk); #1;
            chk($sformatf("v%0d pc", i), bus.pc, tbl[i].e_pc);
            chk($sformatf("v%0d cnt", i), bus.retire_count, tbl[i].e_cnt);
            chk($sformatf("v%0d mis", i), bus.misaligned, tbl[i].e_mis);
            chk($sformatf("v%0d halted", i), bus.halted, tbl[i].e_halt);
            chk($sformatf("v%0d faulted", i), bus.faulted, tbl[i].e_flt);
            chk($sformatf("v%0d bad", i), bus.bad_addr, tbl[i].e_bad);
        end
        idle();

        // Async reset asserted mid-cycle with a redirect pending
        bus.branch_taken = 1; bus.branch_target = 64'hA000;
        #2 reset = 1'b1;
        #1;
        chk("async pc", bus.pc, RV);
        chk("async bad", bus.bad_addr, 64'd0);
        chk("async cnt", bus.retire_count, 64'd0);
        @(posedge clk); #1;
        chk("held rst pc", bus.pc, RV);
        idle();
        @(negedge clk) reset = 1'b0;

`ifdef PC_TRACE_EN
        chk("trace rst count", bus.trace_count, 0);
        for (int i = 0; i < 10; i++) begin
            p[i] = (i == 0) ? RV : 64'h4000 + 64'(i - 1) * 64'h100;
            bus.branch_taken = 1; bus.branch_target = 64'h4000 + 64'(i) * 64'h100;
            @(posedge clk); #1;
        end
        idle();
        chk("trace count", bus.trace_count, 8);
        bus.trace_idx = 3'd0; #1;
        chk("trace idx0", bus.trace_pc, p[9]);
        bus.trace_idx = 3'd7; #1;
        chk("trace idx7", bus.trace_pc, p[2]);
        @(negedge clk) reset = 1'b1;
        #1 chk("trace count rst", bus.trace_count, 0);
        @(negedge clk) reset = 1'b0;
`else
        p[0] = RV;
        chk("idle pc after rst", bus.pc, p[0]);
`endif

        // Randomized run against the model
        @(negedge clk) reset = 1'b1;
        #1 model_reset();
        @(negedge clk) reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1; #2;
                model_reset();
                chk("rand rst pc", bus.pc, m_pc);
                #2 reset = 1'b0;
            end
            bus.stall         = ($urandom_range(0, 7) == 0);
            bus.halt_req      = ($urandom_range(0, 15) == 0);
            bus.resume        = ($urandom_range(0, 3) == 0);
            bus.branch_taken  = ($urandom_range(0, 2) == 0);
            bus.branch_target = rnd_addr(1);
            bus.jalr_valid    = ($urandom_range(0, 3) == 0);
            bus.jalr_target   = rnd_addr(1) | 64'($urandom_range(0, 1));
            bus.trap_req      = ($urandom_range(0, 19) == 0);
            bus.trap_vector   = rnd_addr(0);
`ifdef PC_TRACE_EN
            bus.trace_idx     = 3'($urandom_range(0, 7));
`endif
            model_step();
            @(posedge clk); #1;
            chk("rand pc", bus.pc, m_pc);
            chk("rand plus4", bus.pc_plus4, m_pc + 64'd4);
            chk("rand cnt", bus.retire_count, m_cnt);
            chk("rand mis", bus.misaligned, m_mis);
            chk("rand bad", bus.bad_addr, m_bad);
            chk("rand halted", bus.halted, m_mode == 1);
            chk("rand faulted", bus.faulted, m_mode == 2);
`ifdef PC_TRACE_EN
            chk("rand tcount", bus.trace_count, m_tq.size());
            chk("rand tpc", bus.trace_pc,
                (bus.trace_idx < m_tq.size()) ? m_tq[bus.trace_idx] : 64'd0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
